// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, the frame state enum and the
// parity helper used by the transmitter (and later by the receiver).
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    PAR   = 3'd4,
    STOP  = 3'd5
  } uartState_e;

  // Parity over up to nine data bits; unused upper bits must be zero so they
  // do not disturb the XOR. Even parity is the plain XOR-reduce, odd is its
  // inverse, and "none" yields a constant zero.
  function automatic logic calcParity(input logic [8:0] bits, input int mode);
    logic p;
    p = ^bits;
    if (mode == PARITY_ODD) begin
      p = ~p;
    end else if (mode == PARITY_NONE) begin
      p = 1'b0;
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_tick_detect.sv
// Rising-edge detector for the baud level. bclk comes from a register in the
// same clock domain, so no synchroniser is placed in front of it.
module uart_tick_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic bclk,
  output logic tick
);

  logic bclk_q;

  // Remember last cycle's baud level so a rising edge becomes a one-clk pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_q <= 1'b0;
    end else begin
      bclk_q <= bclk;
    end
  end

  assign tick = bclk & ~bclk_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter. Bytes arrive on a valid/ready handshake and leave on tx
// LSB-first as start, data, optional parity and stop bits. Every bit-level
// step waits for a baud tick; one byte may be queued during the final stop
// period so consecutive frames run without an idle gap.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 bclk,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy
);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : gBadDataBits
    $fatal(1, "uart_tx: DATA_BITS must be in 5..9");
  end
  if (PARITY != PARITY_NONE && PARITY != PARITY_ODD && PARITY != PARITY_EVEN) begin : gBadParity
    $fatal(1, "uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : gBadStopBits
    $fatal(1, "uart_tx: STOP_BITS must be 1 or 2");
  end

  localparam logic [3:0] BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic       STOP_LAST = (STOP_BITS == 2);

  uartState_e           state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 pending_q, pending_d;
  logic [3:0]           bitCnt_q, bitCnt_d;
  logic                 stopCnt_q, stopCnt_d;
  logic                 tx_q, tx_d;

  logic tick;
  logic accept;
  logic lastStop;
  logic parityNow;

  uart_tick_detect uTickDetect (
    .clk     (clk),
    .reset_n (reset_n),
    .bclk    (bclk),
    .tick    (tick)
  );

  assign lastStop  = (state_q == STOP) && (stopCnt_q == STOP_LAST);
  assign ready     = (state_q == IDLE) || (lastStop && !pending_q);
  assign busy      = (state_q != IDLE);
  assign accept    = valid && ready;
  assign parityNow = calcParity(9'(data), PARITY);
  assign tx        = tx_q;

  // Next-state logic: handshake capture first, then the per-state bit sequencing
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    pending_d = pending_q;
    bitCnt_d  = bitCnt_q;
    stopCnt_d = stopCnt_q;
    tx_d      = tx_q;

    // The shift register is idle in IDLE and in the last stop period, which
    // are the only places ready is high, so the byte can load straight in.
    if (accept) begin
      shift_d  = data;
      parity_d = parityNow;
      if (state_q != IDLE) begin
        pending_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (accept) begin
          state_d = SYNC;
        end
      end

      SYNC: begin
        tx_d = 1'b1;
        if (tick) begin
          tx_d    = 1'b0;
          state_d = START;
        end
      end

      START: begin
        if (tick) begin
          tx_d     = shift_q[0];
          bitCnt_d = '0;
          state_d  = DATA;
        end
      end

      DATA: begin
        if (tick) begin
          if (bitCnt_q == BIT_LAST) begin
            if (PARITY != PARITY_NONE) begin
              tx_d    = parity_q;
              state_d = PAR;
            end else begin
              tx_d      = 1'b1;
              stopCnt_d = 1'b0;
              state_d   = STOP;
            end
          end else begin
            shift_d  = shift_q >> 1;
            bitCnt_d = bitCnt_q + 4'd1;
            tx_d     = shift_q[1];
          end
        end
      end

      PAR: begin
        if (tick) begin
          tx_d      = 1'b1;
          stopCnt_d = 1'b0;
          state_d   = STOP;
        end
      end

      STOP: begin
        tx_d = 1'b1;
        if (tick) begin
          if (!lastStop) begin
            stopCnt_d = stopCnt_q + 1'b1;
          end else if (pending_q || accept) begin
            // A byte queued during (or at the very end of) the final stop
            // period starts immediately: the start bit follows with no gap.
            tx_d      = 1'b0;
            pending_d = 1'b0;
            state_d   = START;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset forces the line idle-high at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      pending_q <= 1'b0;
      bitCnt_q  <= '0;
      stopCnt_q <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      pending_q <= pending_d;
      bitCnt_q  <= bitCnt_d;
      stopCnt_q <= stopCnt_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx. Four transmitters with different frame
// formats share one clock and one baud level (16 clk per bit). A frame model
// builds the expected bit list from the byte and format; each bit is sampled
// at its first and last clock, and start latency is predicted from the baud
// phase at the moment of acceptance.
`timescale 1ns/1ps
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       bclk;
  logic [7:0] dataIn [4];
  logic [3:0] validV;
  logic [3:0] readyV;
  logic [3:0] txV;
  logic [3:0] busyV;

  int vectors     = 0;
  int miscompares = 0;
  int bcnt        = 0;
  bit bclkRun     = 1'b1;

  // Channel 0: 8N1, 1: 8 even 1, 2: 8 odd 1, 3: 5N2
  uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dutA (
    .clk(clk), .reset_n(reset_n), .bclk(bclk), .data(dataIn[0]), .valid(validV[0]),
    .ready(readyV[0]), .tx(txV[0]), .busy(busyV[0]));
  uart_tx #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dutB (
    .clk(clk), .reset_n(reset_n), .bclk(bclk), .data(dataIn[1]), .valid(validV[1]),
    .ready(readyV[1]), .tx(txV[1]), .busy(busyV[1]));
  uart_tx #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dutC (
    .clk(clk), .reset_n(reset_n), .bclk(bclk), .data(dataIn[2]), .valid(validV[2]),
    .ready(readyV[2]), .tx(txV[2]), .busy(busyV[2]));
  uart_tx #(.DATA_BITS(5), .PARITY(0), .STOP_BITS(2)) dutD (
    .clk(clk), .reset_n(reset_n), .bclk(bclk), .data(dataIn[3][4:0]), .valid(validV[3]),
    .ready(readyV[3]), .tx(txV[3]), .busy(busyV[3]));

  always #5 clk = ~clk;

  // Baud level: high for counts 8..15 of a 16-clk cycle, changed just after posedge
  initial begin
    bclk = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bclkRun) begin
        bcnt = (bcnt + 1) % 16;
        bclk = (bcnt >= 8);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: observed no finish, required finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Expected line levels for one frame, bit 0 first
  function automatic logic [15:0] frameBits(input int ch, input logic [7:0] b, output int n);
    logic [15:0] r;
    int nb, par, ns;
    logic p;
    nb  = (ch == 3) ? 5 : 8;
    par = (ch == 1) ? 2 : ((ch == 2) ? 1 : 0);
    ns  = (ch == 3) ? 2 : 1;
    r = '1;
    r[0] = 1'b0;
    n = 1;
    p = 1'b0;
    for (int i = 0; i < nb; i++) begin
      r[n] = b[i];
      p = p ^ b[i];
      n++;
    end
    if (par != 0) begin
      r[n] = (par == 1) ? ~p : p;
      n++;
    end
    for (int s = 0; s < ns; s++) begin
      r[n] = 1'b1;
      n++;
    end
    return r;
  endfunction

  // Present a byte and hold valid until it is taken; predicts start latency
  task automatic applyStimulus(input int ch, input logic [7:0] b, output int expLat);
    bit taken;
    int b1, d;
    taken = 1'b0;
    expLat = -1;
    @(posedge clk);
    #1;
    dataIn[ch] = b;
    validV[ch] = 1'b1;
    for (int w = 0; w < 600 && !taken; w++) begin
      @(negedge clk);
      if (readyV[ch] === 1'b1) begin
        b1 = (bcnt + 1) % 16;
        d  = (8 - b1 + 16) % 16;
        expLat = (d == 0) ? 1 : d + 1;
        @(posedge clk);
        #1;
        taken = 1'b1;
      end
    end
    checkOutput($sformatf("ch%0d accepted", ch), 32'(taken), 1);
    validV[ch] = 1'b0;
    dataIn[ch] = 8'($urandom);
  endtask

  // Wait for the start bit's falling edge; returns on the negedge it is first seen
  task automatic waitStart(input int ch, input int expLat, input bit checkLat);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        checkOutput($sformatf("ch%0d syncBusy", ch), 32'(busyV[ch]), 1);
        checkOutput($sformatf("ch%0d syncReady", ch), 32'(readyV[ch]), 0);
      end
    end while (txV[ch] !== 1'b0 && k < 400);
    checkOutput($sformatf("ch%0d startSeen", ch), 32'(txV[ch]), 0);
    if (checkLat) begin
      checkOutput($sformatf("ch%0d startLatency", ch), 32'(k - 1), 32'(expLat));
    end
  endtask

  task automatic runFrame(input int ch, input logic [7:0] b, input bit pendingNext);
    logic [15:0] bits;
    int n;
    bits = frameBits(ch, b, n);
    for (int k = 0; k < n; k++) begin
      checkOutput($sformatf("ch%0d bit%0d early", ch, k), 32'(txV[ch]), 32'(bits[k]));
      checkOutput($sformatf("ch%0d bit%0d busy", ch, k), 32'(busyV[ch]), 1);
      checkOutput($sformatf("ch%0d bit%0d readyEarly", ch, k), 32'(readyV[ch]), 32'(k == n - 1));
      repeat (15) @(negedge clk);
      checkOutput($sformatf("ch%0d bit%0d late", ch, k), 32'(txV[ch]), 32'(bits[k]));
      checkOutput($sformatf("ch%0d bit%0d readyLate", ch, k), 32'(readyV[ch]),
                  32'((k == n - 1) && !pendingNext));
      @(negedge clk);
    end
    if (!pendingNext) begin
      checkOutput($sformatf("ch%0d idleBusy", ch), 32'(busyV[ch]), 0);
      checkOutput($sformatf("ch%0d idleReady", ch), 32'(readyV[ch]), 1);
      checkOutput($sformatf("ch%0d idleTx", ch), 32'(txV[ch]), 1);
    end
  endtask

  task automatic sendOne(input int ch, input logic [7:0] b);
    int lat;
    applyStimulus(ch, b, lat);
    waitStart(ch, lat, 1'b1);
    runFrame(ch, b, 1'b0);
  endtask

  task automatic sendPair(input int ch, input logic [7:0] b1, input logic [7:0] b2);
    int lat, lat2;
    applyStimulus(ch, b1, lat);
    fork
      begin
        waitStart(ch, lat, 1'b1);
        runFrame(ch, b1, 1'b1);
        runFrame(ch, b2, 1'b0);
      end
      applyStimulus(ch, b2, lat2);
    join
  endtask

  // Accept a byte with the baud level frozen, confirm nothing moves, then resume
  task automatic stuckTest(input int ch, input int freezeAt);
    int lat, bad;
    logic [7:0] b;
    b = 8'($urandom);
    do @(negedge clk); while (bcnt != freezeAt);
    bclkRun = 1'b0;
    applyStimulus(ch, b, lat);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (txV[ch] !== 1'b1 || busyV[ch] !== 1'b1) bad++;
    end
    checkOutput($sformatf("ch%0d stuckHold bclk=%0d", ch, bclk), 32'(bad), 0);
    bclkRun = 1'b1;
    waitStart(ch, 0, 1'b0);
    runFrame(ch, b, 1'b0);
  endtask

  initial begin
    logic [7:0] b, b2;
    int lat, ch;

    reset_n = 1'b0;
    validV  = '0;
    for (int i = 0; i < 4; i++) dataIn[i] = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("ch%0d resetTx", i), 32'(txV[i]), 1);
      checkOutput($sformatf("ch%0d resetBusy", i), 32'(busyV[i]), 0);
      checkOutput($sformatf("ch%0d resetReady", i), 32'(readyV[i]), 1);
    end
    #2 reset_n = 1'b1;
    repeat (20) @(negedge clk);

    $display("[TB] single byte, back-to-back, parity, two stop bits");
    sendOne(0, 8'hA5);
    sendPair(0, 8'h00, 8'hFF);
    sendOne(1, 8'h07);
    sendOne(2, 8'h07);
    sendOne(3, 8'h1F);

    $display("[TB] accept coincident with a baud tick");
    do @(negedge clk); while (bcnt != 7);
    applyStimulus(0, 8'h5A, lat);
    waitStart(0, 16, 1'b1);
    runFrame(0, 8'h5A, 1'b0);

    $display("[TB] reset during data bit 3");
    b = 8'($urandom) & 8'hF7;
    applyStimulus(0, b, lat);
    waitStart(0, lat, 1'b1);
    repeat (64 + 6) @(negedge clk);
    checkOutput("preResetTx", 32'(txV[0]), 0);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("asyncResetTx", 32'(txV[0]), 1);
    checkOutput("asyncResetBusy", 32'(busyV[0]), 0);
    checkOutput("asyncResetReady", 32'(readyV[0]), 1);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (10) @(negedge clk);
    sendOne(0, 8'h3C);

    $display("[TB] baud level stuck low and high");
    stuckTest(2, 3);
    stuckTest(3, 12);

    $display("[TB] randomized frames");
    for (int it = 0; it < 40; it++) begin
      ch = $urandom_range(0, 3);
      b  = 8'($urandom);
      b2 = 8'($urandom);
      repeat ($urandom_range(0, 40)) @(negedge clk);
      if ($urandom_range(0, 3) == 0) sendPair(ch, b, b2);
      else sendOne(ch, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
